ps2_keyboard_rx: RTL and testbench
==================================

Name: ps2_keyboard_rx

Overview:
PS/2 keyboard receiver with a buffered output. It synchronises ps2_clk/ps2_data and samples each frame bit on the falling edge of ps2_clk. It validates the frame (start, odd parity, stop) and folds the E0 (extended) and F0 (break) prefixes into flags on the following scancode. Decoded codes go into a parametrised FIFO drained by a valid/ready consumer, such as the ASCII lookup or display logic in the NVBoard top level.

Parameters:
FIFO_DEPTH, 8, number of buffered entries; power of 2, minimum 2
SYNC_STAGES, 3, synchroniser flops per PS/2 input; minimum 2
TIMEOUT_CYCLES, 50000, clk cycles with no ps2_clk falling edge after which a partial frame is abandoned

Ports:
clk  input  1  system clock; the only clock
reset  input  1  asynchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock from the keyboard
ps2_data  input  1  raw PS/2 data from the keyboard
code_valid  output  1  FIFO non-empty; head entry presented
code_ready  input  1  consumer accepts the head entry when code_valid is also high
code_data  output  8  scancode byte at the FIFO head
code_ext  output  1  head entry was preceded by E0
code_break  output  1  head entry was preceded by F0 (key release)
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
frame_err  output  1  one-cycle pulse on a bad frame or timeout
overflow  output  1  sticky; a decoded entry was dropped because the FIFO was full
err_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset (async, active-high): code_valid=0, fifo_count=0, frame_err=0, overflow=0. Bit counter, shift register, prefix flags, timeout counter and FIFO pointers all cleared. Synchroniser flops reset to 1 (idle bus). A reset mid-frame discards the partial frame; no entry and no error are produced.
- Sync: each input passes through SYNC_STAGES flops. fall = sync_prev_clk & ~sync_clk, where both are synchronised values of ps2_clk. The data bit is the synchronised ps2_data in the same cycle.
- Frame: 11 bits, LSB first: start(0), d[7:0], parity, stop(1). On each fall, store the bit at index bitcnt and increment bitcnt (0..10).
- On the fall that captures bit 10, the frame is evaluated in that same cycle, and bitcnt returns to 0.
  - Valid frame: start==0, stop==1, and ^{d,parity}==1 (odd parity).
  - Invalid frame: frame_err=1 for the next cycle, byte discarded, ext and brk flags cleared.
- Prefix decode (valid frames only):
  - d==E0: set ext; no push.
  - d==F0: set brk; no push.
  - Any other d: push {ext,brk,d}, then clear ext and brk. A dropped push (FIFO full) also clears the flags.
- Timeout:
  - The counter runs while bitcnt!=0 and resets on every fall.
  - When it reaches TIMEOUT_CYCLES: bitcnt=0, frame_err pulses for one cycle, flags are kept.
  - The counter holds at 0 while idle (bitcnt==0).
- FIFO:
  - Entries are 10 bits wide; synchronous write; the head is driven from the storage array.
  - Push occurs on the clock edge following evaluation. code_valid rises 2 clk cycles after the final ps2_clk falling edge is detected.
  - Pop on code_valid & code_ready; head advances next cycle.
  - Push and pop in the same cycle: both happen and fifo_count is unchanged. This includes the full case, where the push is accepted.
  - Push when full without a pop: entry dropped, overflow=1.
  - Pop when empty: impossible, since code_valid=0.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- overflow clears on err_clr. If err_clr and a drop occur in the same cycle, set wins.
- Outputs code_data, code_ext and code_break are undefined (don't-care) while code_valid=0. The bench must not check them then.

Decomposition:
- Package ps2_pkg:
  - PS2_EXT_PREFIX=8'hE0, PS2_BRK_PREFIX=8'hF0, PS2_FRAME_BITS=11.
  - Packed typedef ps2_code_t {ext, brk, data[7:0]}.
- Sub-module ps2_rx_fifo: generic valid/ready FIFO parametrised on width and depth, with full/empty/count. The top keeps sync, framing, timeout and prefix logic.

Test Plan:
- Valid frame 0x1C (parity 0), code_ready=1 -> one entry: code_data=0x1C, ext=0, break=0; frame_err stays 0.
- Frames F0, 1C -> exactly one entry: code_data=0x1C, break=1, ext=0; fifo_count peaks at 1.
- Frames E0, F0, 75 -> one entry: code_data=0x75, ext=1, break=1. A following 0x74 gives ext=0, break=0.
- Frame 0x1C with parity=1, then valid 0x1B -> frame_err pulses once, no entry for 0x1C, one entry 0x1B. Same for start=1 and for stop=0.
- code_ready=0, send FIFO_DEPTH+1 valid bytes 0x01..0x09 -> fifo_count=8, overflow=1. Drain yields 0x01..0x08 in order. err_clr clears overflow.
- Send 5 bits, hold ps2_clk high for more than TIMEOUT_CYCLES, then a valid frame 0x2A -> one frame_err pulse, then one entry 0x2A. Repeat with reset asserted mid-frame -> no error and no entry.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and the buffered scancode entry format for the PS/2 receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
    localparam int unsigned PS2_FRAME_BITS = 11;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] data;
    } ps2_code_t;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Generic valid/ready FIFO; a write into a full FIFO is accepted when a pop frees a slot in the same cycle.
module ps2_rx_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = out_ready & ~empty;
    assign do_push  = in_valid & (~full | do_pop);
    assign out_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: input sync, 11-bit frame capture with timeout, E0/F0 prefix folding, buffered output.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SYNC_STAGES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          code_valid,
    input  logic                          code_ready,
    output logic [7:0]                    code_data,
    output logic                          code_ext,
    output logic                          code_break,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          err_clr
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   data_bit;

    logic [3:0]             bitcnt;
    logic [9:0]             shreg;
    logic [TW-1:0]          tmo;
    logic                   ext;
    logic                   brk;
    logic                   push_req;
    ps2_code_t              push_code;

    logic [10:0]            frame;
    logic                   frame_ok;
    logic [7:0]             frame_byte;
    logic                   last_bit;

    ps2_code_t              head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall     = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign data_bit = data_sync[SYNC_STAGES-1];

    // The stop bit is never stored; the frame is judged using the live bit on the final fall.
    assign frame      = {data_bit, shreg};
    assign frame_byte = frame[8:1];
    assign frame_ok   = ~frame[0] & frame[10] & (^frame[9:1]);
    assign last_bit   = (bitcnt == 4'(PS2_FRAME_BITS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitcnt    <= '0;
            shreg     <= '0;
            tmo       <= '0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            frame_err <= 1'b0;
            push_req  <= 1'b0;
            push_code <= '0;
        end else begin
            frame_err <= 1'b0;
            push_req  <= 1'b0;
            if (fall) begin
                tmo <= '0;
                if (last_bit) begin
                    bitcnt <= '0;
                    if (!frame_ok) begin
                        frame_err <= 1'b1;
                        ext       <= 1'b0;
                        brk       <= 1'b0;
                    end else if (frame_byte == PS2_EXT_PREFIX) begin
                        ext <= 1'b1;
                    end else if (frame_byte == PS2_BRK_PREFIX) begin
                        brk <= 1'b1;
                    end else begin
                        push_req  <= 1'b1;
                        push_code <= '{ext: ext, brk: brk, data: frame_byte};
                        ext       <= 1'b0;
                        brk       <= 1'b0;
                    end
                end else begin
                    shreg[bitcnt] <= data_bit;
                    bitcnt        <= bitcnt + 4'd1;
                end
            end else if (bitcnt != '0) begin
                if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                    bitcnt    <= '0;
                    tmo       <= '0;
                    frame_err <= 1'b1;
                end else begin
                    tmo <= tmo + TW'(1);
                end
            end
        end
    end

    assign code_valid = ~fifo_empty;
    assign drop       = push_req & fifo_full & ~(code_valid & code_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (err_clr) begin
            overflow <= 1'b0;
        end
    end

    ps2_rx_fifo #(
        .WIDTH ($bits(ps2_code_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (push_req),
        .in_data   (push_code),
        .out_ready (code_ready),
        .out_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign code_data  = head.data;
    assign code_ext   = head.ext;
    assign code_break = head.brk;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed plus randomized bench for ps2_keyboard_rx with a frame-level reference model.
module tb_ps2_keyboard_rx;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int HP    = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       code_valid;
    logic       code_ready;
    logic [7:0] code_data;
    logic       code_ext;
    logic       code_break;
    logic [3:0] fifo_count;
    logic       frame_err;
    logic       overflow;
    logic       err_clr;

    always #5 clk = ~clk;

    ps2_keyboard_rx #(
        .FIFO_DEPTH     (DEPTH),
        .SYNC_STAGES    (3),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_data  (code_data),
        .code_ext   (code_ext),
        .code_break (code_break),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .err_clr    (err_clr)
    );

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int max_cnt = 0;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    int exp_err = 0;
    bit exp_ovf = 0;
    bit m_ext = 0;
    bit m_brk = 0;
    int m_occ = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) err_seen++;
            if (code_valid && code_ready) got_q.push_back({code_ext, code_break, code_data});
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            cycles(HP);
            ps2_clk = 1'b0;
            cycles(HP);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic model_push(input logic [9:0] e);
        if (code_ready) begin
            exp_q.push_back(e);
        end else if (m_occ == DEPTH) begin
            exp_ovf = 1;
        end else begin
            exp_q.push_back(e);
            m_occ++;
        end
    endtask

    // kind: 0 good, 1 bad parity, 2 bad start, 3 bad stop
    task automatic send_frame(input logic [7:0] d, input int kind);
        logic [10:0] bits;
        bits = {1'b1, ~(^d), d, 1'b0};
        if (kind == 1) bits[9] = ~bits[9];
        if (kind == 2) bits[0] = 1'b1;
        if (kind == 3) bits[10] = 1'b0;
        send_bits(bits, 11);
        if (kind != 0) begin
            exp_err++;
            m_ext = 0;
            m_brk = 0;
        end else if (d == 8'hE0) begin
            m_ext = 1;
        end else if (d == 8'hF0) begin
            m_brk = 1;
        end else begin
            model_push({m_ext, m_brk, d});
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic check_all(input string tag);
        cycles(10);
        chk({tag, " entries"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, " entry"}, int'(got_q.pop_front()), int'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
        chk({tag, " frame_err"}, err_seen, exp_err);
        chk({tag, " overflow"}, int'(overflow), int'(exp_ovf));
        chk({tag, " fifo_count"}, int'(fifo_count), m_occ);
        chk({tag, " code_valid"}, int'(code_valid), int'(m_occ != 0));
    endtask

    initial begin
        logic [10:0] partial;
        reset      = 1'b1;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        code_ready = 1'b1;
        err_clr    = 1'b0;
        cycles(5);
        chk("rst code_valid", int'(code_valid), 0);
        chk("rst fifo_count", int'(fifo_count), 0);
        chk("rst frame_err", int'(frame_err), 0);
        chk("rst overflow", int'(overflow), 0);
        reset = 1'b0;
        cycles(5);

        send_frame(8'h1C, 0);
        check_all("plain");

        max_cnt = 0;
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        check_all("break");
        chk("break peak", max_cnt, 1);

        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h75, 0);
        send_frame(8'h74, 0);
        check_all("ext_break");

        for (int k = 1; k <= 3; k++) begin
            send_frame(8'h1C, k);
            send_frame(8'h1B, 0);
        end
        check_all("bad_frames");

        code_ready = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 0);
        cycles(10);
        chk("ovf fifo_count", int'(fifo_count), m_occ);
        chk("ovf overflow", int'(overflow), int'(exp_ovf));
        chk("ovf code_valid", int'(code_valid), 1);
        chk("ovf head", int'(code_data), 1);
        code_ready = 1'b1;
        m_occ = 0;
        check_all("drain");
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        exp_ovf = 0;
        cycles(2);
        chk("err_clr overflow", int'(overflow), 0);

        partial = {1'b1, ~(^8'h2A), 8'h2A, 1'b0};
        send_bits(partial, 5);
        cycles(TMO + 100);
        exp_err++;
        chk("timeout frame_err", err_seen, exp_err);
        send_frame(8'h2A, 0);
        check_all("after_timeout");

        send_bits(partial, 5);
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        m_ext = 0;
        m_brk = 0;
        exp_ovf = 0;
        cycles(TMO + 100);
        chk("reset_mid frame_err", err_seen, exp_err);
        chk("reset_mid fifo_count", int'(fifo_count), 0);
        send_frame(8'h2A, 0);
        check_all("after_reset");

        for (int n = 0; n < 24; n++) begin
            int r;
            logic [7:0] d;
            int kind;
            r = $urandom_range(0, 9);
            if (r < 2) d = 8'hE0;
            else if (r < 4) d = 8'hF0;
            else d = 8'($urandom_range(0, 255));
            kind = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_frame(d, kind);
        end
        check_all("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
